// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Converts one RISC-V load/store per instruction into a single word-aligned
//   memory bus transaction. The effective address comes straight from the ALU.
//   Stores get per-byte strobes and lane-replicated data. Loads get the
//   addressed lane sign/zero-extended. The core is stalled while the access
//   is in flight. Misaligned, illegal-encoding and bus-timeout cases abort
//   with a one-cycle fault pulse instead of completing.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   lsu_valid          instruction valid for the LSU
//   is_load, is_store  access type (both high = illegal)
//   funct3             RISC-V width/sign field
//   addr               effective address
//   store_data         rs2 value
//   stall              hold PC/instruction (combinational)
//   done               1-cycle success pulse; load_data valid with it
//   load_data          extended load result, held until the next load
//   fault, fault_cause 1-cycle abort pulse; 01 misaligned, 10 timeout,
//                      11 illegal encoding
//   mem_req/we/addr/wstrb/wdata   bus request, held stable until mem_ready
//   mem_ready, mem_rdata          bus handshake and read data
// ---------------------------------------------------------------------------

// One byte lane of the store path: strobe bit and source byte for this lane.
module lsu_byte_lane #(
    parameter int unsigned LANE = 0
) (
    input  logic [1:0] size,    // funct3[1:0]: 00 byte, 01 half, 10 word
    input  logic [1:0] off,     // addr[1:0]
    input  logic [31:0] sd,
    output logic        strb,
    output logic [7:0]  wbyte
);
    localparam logic [1:0] L = 2'(LANE);

    // Which byte of store_data feeds this lane after replication.
    logic [1:0] src;

    always_comb begin
        strb = 1'b0;
        src  = 2'b00;
        case (size)
            2'b00: begin
                strb = (off == L);
                src  = 2'b00;
            end
            // Halfwords are aligned here, so off[1] picks the lane pair.
            2'b01: begin
                strb = (off[1] == L[1]);
                src  = {1'b0, L[0]};
            end
            2'b10: begin
                strb = 1'b1;
                src  = L;
            end
            default: begin
                strb = 1'b0;
                src  = 2'b00;
            end
        endcase
    end

    always_comb begin
        case (src)
            2'd0:    wbyte = sd[7:0];
            2'd1:    wbyte = sd[15:8];
            2'd2:    wbyte = sd[23:16];
            default: wbyte = sd[31:24];
        endcase
    end
endmodule

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lsu_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned NUM_LANES = 4;
    // Counter value on the last BUSY cycle the bus is allowed.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    // What the load path needs to remember once the instruction has moved on.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] off;
    } req_t;

    state_t      state;
    req_t        req_q;
    logic [15:0] cnt;

    logic        start;
    logic        illegal;
    logic        misaligned;

    logic [NUM_LANES-1:0]        strb_c;
    logic [NUM_LANES-1:0][7:0]   wdata_c;

    logic [31:0] lane_w;
    logic [31:0] ext;

    // ------------------------------------------------------------------
    // Decode of the instruction presented in IDLE
    // ------------------------------------------------------------------
    assign start = lsu_valid & (is_load | is_store);

    always_comb begin
        illegal = 1'b0;
        if (is_load & is_store) begin
            illegal = 1'b1;
        end else if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
                default:                                illegal = 1'b1;
            endcase
        end else if (is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: illegal = 1'b0;
                default:                illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lanes: strobes and replicated data, captured on entry to BUSY
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            lsu_byte_lane #(.LANE(gi)) u_lane (
                .size  (funct3[1:0]),
                .off   (addr[1:0]),
                .sd    (store_data),
                .strb  (strb_c[gi]),
                .wbyte (wdata_c[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load extraction from the returning bus word
    // ------------------------------------------------------------------
    always_comb begin
        lane_w = mem_rdata >> {req_q.off, 3'b000};
        case (req_q.funct3)
            3'b000:  ext = {{24{lane_w[7]}},  lane_w[7:0]};
            3'b001:  ext = {{16{lane_w[15]}}, lane_w[15:0]};
            3'b100:  ext = {24'd0, lane_w[7:0]};
            3'b101:  ext = {16'd0, lane_w[15:0]};
            default: ext = lane_w;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall: only IDLE depends on the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        if (!resetn)
            stall = 1'b0;
        else if (state == IDLE)
            stall = start;
        else
            stall = (state == BUSY);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered bus and result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            req_q       <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            load_data   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= 4'b0000;
            mem_wdata   <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            done  <= 1'b0;
            fault <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            state       <= ERR;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                        end else if (misaligned) begin
                            state       <= ERR;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            state         <= BUSY;
                            req_q.funct3  <= funct3;
                            req_q.off     <= addr[1:0];
                            cnt           <= '0;
                            mem_req       <= 1'b1;
                            mem_we        <= is_store;
                            mem_addr      <= {addr[31:2], 2'b00};
                            mem_wstrb     <= is_store ? strb_c : 4'b0000;
                            mem_wdata     <= wdata_c;
                        end
                    end
                end

                BUSY: begin
                    // Success is checked first so a late ready on the
                    // final allowed cycle still completes.
                    if (mem_ready) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (!mem_we)
                            load_data <= ext;
                    end else if (cnt == TO_LAST) begin
                        state       <= ERR;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_wstrb   <= 4'b0000;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                ERR: begin
                    state       <= IDLE;
                    fault_cause <= 2'b00;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        lsu_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .lsu_valid(lsu_valid), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .done(done), .load_data(load_data), .fault(fault),
        .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ld_model = '0;   // architectural value load_data should hold

    // Observations of the last access
    int          o_stall, o_req;
    logic        o_done, o_fault, o_stable, o_tmo, o_extra;
    logic [1:0]  o_cause;
    logic [31:0] o_ld, o_addr, o_wdata;
    logic        o_we;
    logic [3:0]  o_strb;

    // Present one instruction, act as the memory (ready after wt request
    // cycles), and record what the bus and core side saw.
    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int wt);
        int  reqi;
        bit  fin;
        @(posedge clk); #1;
        lsu_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; store_data = sd;
        o_stall = 0; o_req = 0; o_done = 0; o_fault = 0; o_cause = 0;
        o_stable = 1; o_tmo = 0; o_addr = 0; o_we = 0; o_strb = 0; o_wdata = 0;
        o_ld = 0; reqi = 0; fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (stall) o_stall++;
            if (done | fault) begin
                o_done = done; o_fault = fault; o_cause = fault_cause;
                o_ld = load_data; fin = 1;
            end
            if (mem_req) begin
                if (reqi == 0) begin
                    o_addr = mem_addr; o_we = mem_we; o_strb = mem_wstrb; o_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {o_addr, o_we, o_strb, o_wdata}) begin
                    o_stable = 0;
                end
                o_req++;
                mem_ready = (reqi == wt);
                mem_rdata = (reqi == wt) ? rd : $urandom;
                reqi++;
            end else begin
                // ready outside a request must be ignored
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
        if (!fin) o_tmo = 1;
        @(posedge clk); #1;
        lsu_valid = 0; is_load = 0; is_store = 0; mem_ready = 0;
        @(negedge clk);
        o_extra = done | fault | mem_req;
    endtask

    // Reference: what an access should look like, from the ISA rules.
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rd, input int wt,
                                  output int cause, output int e_stall, output int e_req,
                                  output logic [3:0] e_strb, output logic [31:0] e_wd,
                                  output logic [31:0] e_ld);
        bit legal;
        int sz, off;
        logic [31:0] sh, mask;
        legal = !(ld && st) &&
                (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}));
        e_strb = 0; e_wd = 0; e_ld = 0;
        if (!legal) begin
            cause = 3; e_stall = 1; e_req = 0;
            return;
        end
        sz  = 1 << f3[1:0];
        off = int'(a % 32'd4);
        if (int'(a % 32'(sz)) != 0) begin
            cause = 1; e_stall = 1; e_req = 0;
            return;
        end
        if (wt >= TO) begin
            cause = 2; e_stall = 1 + TO; e_req = TO;
        end else begin
            cause = 0; e_stall = 2 + wt; e_req = wt + 1;
        end
        e_strb = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        sh   = rd >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
        e_ld = sh & mask;
        if (!f3[2] && sz < 4 && sh[8*sz-1]) e_ld = e_ld | ~mask;
    endfunction

    task automatic test_reset();
        resetn = 0; lsu_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010;
        addr = 32'h100; store_data = 0; mem_ready = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_cmp++;
        if ({mem_req, mem_we, done, fault, fault_cause, mem_wstrb} !== 10'b0) begin
            n_bad++; $display("FAIL reset_ctrl got req=%b we=%b done=%b fault=%b cause=%b strb=%b exp all 0",
                              mem_req, mem_we, done, fault, fault_cause, mem_wstrb);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, load_data} !== 96'b0) begin
            n_bad++; $display("FAIL reset_data got addr=%h wdata=%h ld=%h exp 0", mem_addr, mem_wdata, load_data);
        end
        lsu_valid = 0; is_load = 0;
        @(posedge clk); #1;
        resetn = 1;
        ld_model = 0;
    endtask

    task automatic test_lw();
        access(1, 0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 0);
        ld_model = 32'hDEADBEEF;
        n_cmp++;
        if ({o_addr, o_strb, o_we} !== {32'h1000, 4'b0000, 1'b0}) begin
            n_bad++; $display("FAIL lw_bus got addr=%h strb=%b we=%b exp 00001000/0000/0", o_addr, o_strb, o_we);
        end
        n_cmp++;
        if (o_done !== 1'b1 || o_ld !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_done got done=%b ld=%h exp 1/deadbeef", o_done, o_ld);
        end
        n_cmp++;
        if (o_stall != 2 || o_req != 1) begin
            n_bad++; $display("FAIL lw_stall got stall=%0d req=%0d exp 2/1", o_stall, o_req);
        end
    endtask

    task automatic test_sb();
        access(0, 1, 3'b000, 32'h2003, 32'h000000A5, 32'h12345678, 0);
        n_cmp++;
        if ({o_addr, o_strb, o_wdata, o_we} !== {32'h2000, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
            n_bad++; $display("FAIL sb_bus got addr=%h strb=%b wd=%h we=%b exp 00002000/1000/a5a5a5a5/1",
                              o_addr, o_strb, o_wdata, o_we);
        end
        n_cmp++;
        if (o_done !== 1'b1 || o_ld !== ld_model) begin
            n_bad++; $display("FAIL sb_done got done=%b ld=%h exp 1/%h", o_done, o_ld, ld_model);
        end
    endtask

    task automatic test_ext();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] as  [3] = '{32'h401, 32'h405, 32'h40A};
        logic [31:0] exps[3] = '{32'h0000007F, 32'h0000007F, 32'hFFFF80F1};
        for (int i = 0; i < 3; i++) begin
            access(1, 0, f3s[i], as[i], 32'h0, 32'h80F17F00, i);
            n_cmp++;
            if (o_done !== 1'b1 || o_ld !== exps[i]) begin
                n_bad++; $display("FAIL ext_%0d got done=%b ld=%h exp 1/%h", i, o_done, o_ld, exps[i]);
            end
            ld_model = exps[i];
        end
    endtask

    task automatic test_faults();
        logic        lds[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic        sts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s[4] = '{3'b010, 3'b011, 3'b010, 3'b011};
        logic [31:0] as [4] = '{32'h1002, 32'h1000, 32'h1000, 32'h1001};
        logic [1:0]  cs [4] = '{2'b01, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 4; i++) begin
            access(lds[i], sts[i], f3s[i], as[i], 32'h0, 32'h0, 0);
            n_cmp++;
            if (o_fault !== 1'b1 || o_done !== 1'b0 || o_cause !== cs[i]) begin
                n_bad++; $display("FAIL fault_%0d got fault=%b done=%b cause=%b exp 1/0/%b",
                                  i, o_fault, o_done, o_cause, cs[i]);
            end
            n_cmp++;
            if (o_req != 0 || o_stall != 1 || o_ld !== ld_model) begin
                n_bad++; $display("FAIL fault_%0d_bus got req=%0d stall=%0d ld=%h exp 0/1/%h",
                                  i, o_req, o_stall, o_ld, ld_model);
            end
        end
    endtask

    task automatic test_timeout();
        access(1, 0, 3'b010, 32'h3000, 32'h0, 32'h0, 100);
        n_cmp++;
        if (o_req != TO || o_fault !== 1'b1 || o_done !== 1'b0 || o_cause !== 2'b10 || o_extra !== 1'b0) begin
            n_bad++; $display("FAIL timeout got req=%0d fault=%b done=%b cause=%b after=%b exp %0d/1/0/10/0",
                              o_req, o_fault, o_done, o_cause, o_extra, TO);
        end
        // ready on the last allowed cycle still succeeds
        access(1, 0, 3'b010, 32'h3004, 32'h0, 32'hCAFEF00D, TO - 1);
        ld_model = 32'hCAFEF00D;
        n_cmp++;
        if (o_req != TO || o_done !== 1'b1 || o_fault !== 1'b0 || o_ld !== 32'hCAFEF00D || o_stable !== 1'b1) begin
            n_bad++; $display("FAIL timeout_edge got req=%0d done=%b fault=%b ld=%h stable=%b exp %0d/1/0/cafef00d/1",
                              o_req, o_done, o_fault, o_ld, o_stable, TO);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(posedge clk); #1;
        lsu_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h5000;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy got req=%b exp 1", mem_req); end
        resetn = 0; mem_ready = 0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_req, done, fault, stall} !== 4'b0 || load_data !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_edge got req=%b done=%b fault=%b stall=%b ld=%h exp 0",
                              mem_req, done, fault, stall, load_data);
        end
        ld_model = 0;
        resetn = 1; lsu_valid = 0; is_load = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            seen = seen | done | fault | mem_req;
        end
        mem_ready = 0;
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet got activity=%b exp 0", seen); end
        access(1, 0, 3'b010, 32'h5000, 32'h0, 32'h0BADC0DE, 1);
        ld_model = 32'h0BADC0DE;
        n_cmp++;
        if (o_done !== 1'b1 || o_ld !== 32'h0BADC0DE || o_stall != 3) begin
            n_bad++; $display("FAIL rstmid_next got done=%b ld=%h stall=%0d exp 1/0badc0de/3", o_done, o_ld, o_stall);
        end
    endtask

    task automatic test_random();
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd, e_wd, e_ld;
        logic [3:0]  e_strb;
        int          r, wt, cause, e_stall, e_req;
        logic [2:0]  legal_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            ld = (r <= 5); st = (r == 0) || (r >= 6);
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, st ? 2 : 4)] : 3'($urandom);
            a  = $urandom; sd = $urandom; rd = $urandom;
            wt = $urandom_range(0, 5);
            model(ld, st, f3, a, sd, rd, wt, cause, e_stall, e_req, e_strb, e_wd, e_ld);
            access(ld, st, f3, a, sd, rd, wt);
            if (cause == 0 && ld && !st) ld_model = e_ld;
            n_cmp++;
            if (o_tmo !== 1'b0 || o_extra !== 1'b0 || o_stable !== 1'b1) begin
                n_bad++; $display("FAIL rnd%0d_proto got hang=%b after=%b stable=%b exp 0/0/1", i, o_tmo, o_extra, o_stable);
            end
            n_cmp++;
            if (o_done !== (cause == 0) || o_fault !== (cause != 0) || (cause != 0 && o_cause !== 2'(cause))) begin
                n_bad++; $display("FAIL rnd%0d_result got done=%b fault=%b cause=%0d exp cause %0d",
                                  i, o_done, o_fault, o_cause, cause);
            end
            n_cmp++;
            if (o_stall != e_stall || o_req != e_req) begin
                n_bad++; $display("FAIL rnd%0d_cycles got stall=%0d req=%0d exp %0d/%0d", i, o_stall, o_req, e_stall, e_req);
            end
            if (e_req > 0) begin
                n_cmp++;
                if (o_addr !== {a[31:2], 2'b00} || o_we !== st || o_strb !== (st ? e_strb : 4'b0)) begin
                    n_bad++; $display("FAIL rnd%0d_bus got addr=%h we=%b strb=%b exp %h/%b/%b",
                                      i, o_addr, o_we, o_strb, {a[31:2], 2'b00}, st, st ? e_strb : 4'b0);
                end
                if (st) begin
                    n_cmp++;
                    if (o_wdata !== e_wd) begin
                        n_bad++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o_wdata, e_wd);
                    end
                end
            end
            n_cmp++;
            if (o_ld !== ld_model) begin
                n_bad++; $display("FAIL rnd%0d_ld got %h exp %h", i, o_ld, ld_model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_ext();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
